npuarc_mmu_ntlb_pd1_ctrl: RTL and testbench

Access controller sitting directly upstream of the nTLB PD1 data RAM (npuarc_mmu_ntlb_pd1_ram). It arbitrates between nTLB lookup reads, refill writes and a hardware invalidate-all sweep, and drives the RAM's single address/data port. It returns lookup read data with a fixed latency and sequences the RAM's deep-sleep and shutdown power modes, including a counted wake-up interval.

---
 rtl/npuarc_mmu_ntlb_pd1_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_npuarc_mmu_ntlb_pd1_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npuarc_mmu_ntlb_pd1_ctrl.sv
// nTLB PD1 RAM access controller: arbitrates sweep > refill write > lookup and sequences WAKE/RUN/DS/SD power modes.
// Lookup data arrives 1 cycle after ack (2 with NPUARC_NTLB_PD1_RDATA_REG_EN); requests stall (no ack) during a sweep or outside RUN.
module npuarc_mmu_ntlb_pd1_ctrl #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 7,
   parameter int DEPTH       = 128,
   parameter int WAKE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_a,
   input  logic              lkp_req,
   input  logic [ADDR_W-1:0] lkp_addr,
   output logic              lkp_ack,
   output logic              lkp_rvalid,
   output logic [DATA_W-1:0] lkp_rdata,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              inv_start,
   output logic              inv_busy,
   output logic              inv_done,
   input  logic              pwr_ds_req,
   input  logic              pwr_sd_req,
   output logic              pwr_rdy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_cs,
   output logic              ram_we,
   output logic              ram_ds,
   output logic              ram_sd,
   output logic              ram_ls,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam int CNT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_WAKE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DS   = 2'd2,
      ST_SD   = 2'd3
   } pwr_state_t;

   pwr_state_t        state, state_nxt;
   logic [CNT_W-1:0]  wake_cnt, wake_cnt_nxt;
   logic              inv_busy_q;
   logic              inv_done_q;
   logic [ADDR_W-1:0] inv_idx;
   logic              rd_pend;
   logic              rd_inflight;
   logic              run_idle;

   // Single RAM port: at most one of sweep, write, lookup per cycle.
   always_comb begin
      lkp_ack  = 1'b0;
      wr_ack   = 1'b0;
      ram_cs   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
      if (state == ST_RUN) begin
         if (inv_busy_q) begin
            ram_cs   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = inv_idx;
         end else if (wr_req) begin
            wr_ack   = 1'b1;
            ram_cs   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = wr_addr;
            ram_din  = wr_data;
         end else if (lkp_req) begin
            lkp_ack  = 1'b1;
            ram_cs   = 1'b1;
            ram_addr = lkp_addr;
         end
      end
   end

   // RUN may only be left when the RAM port is completely quiet.
   assign run_idle = !inv_busy_q && !rd_inflight && !lkp_req && !wr_req && !inv_start;

   always_comb begin
      state_nxt    = state;
      wake_cnt_nxt = wake_cnt;
      case (state)
         ST_WAKE: begin
            if (wake_cnt == '0) begin
               if (pwr_sd_req)      state_nxt = ST_SD;
               else if (pwr_ds_req) state_nxt = ST_DS;
               else                 state_nxt = ST_RUN;
            end else begin
               wake_cnt_nxt = wake_cnt - 1'b1;
            end
         end
         ST_RUN: begin
            if (run_idle && (pwr_sd_req || pwr_ds_req))
               state_nxt = pwr_sd_req ? ST_SD : ST_DS;
         end
         ST_DS: begin
            if (pwr_sd_req) begin
               state_nxt = ST_SD;
            end else if (!pwr_ds_req) begin
               state_nxt    = ST_WAKE;
               wake_cnt_nxt = WAKE_LOAD;
            end
         end
         ST_SD: begin
            if (!pwr_sd_req && !pwr_ds_req) begin
               state_nxt    = ST_WAKE;
               wake_cnt_nxt = WAKE_LOAD;
            end
         end
         default: begin
            state_nxt    = ST_WAKE;
            wake_cnt_nxt = WAKE_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         state    <= ST_WAKE;
         wake_cnt <= WAKE_LOAD;
      end else begin
         state    <= state_nxt;
         wake_cnt <= wake_cnt_nxt;
      end
   end

   // Sweep index stops at the last entry; busy drops and done pulses together.
   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         inv_busy_q <= 1'b0;
         inv_done_q <= 1'b0;
         inv_idx    <= '0;
      end else begin
         inv_done_q <= inv_busy_q && (inv_idx == LAST_IDX);
         if (inv_busy_q) begin
            if (inv_idx == LAST_IDX) inv_busy_q <= 1'b0;
            else                     inv_idx    <= inv_idx + 1'b1;
         end else if ((state == ST_RUN) && inv_start) begin
            inv_busy_q <= 1'b1;
            inv_idx    <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) rd_pend <= 1'b0;
      else        rd_pend <= lkp_ack;
   end

`ifdef NPUARC_NTLB_PD1_RDATA_REG_EN
   logic              rvalid_q;
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= rd_pend;
         rdata_q  <= rd_pend ? ram_dout : '0;
      end
   end

   assign rd_inflight = rd_pend || rvalid_q;
   assign lkp_rvalid  = rvalid_q;
   assign lkp_rdata   = rdata_q;
`else
   // Gated so the data bus reads zero whenever no read is being returned.
   assign rd_inflight = rd_pend;
   assign lkp_rvalid  = rd_pend;
   assign lkp_rdata   = rd_pend ? ram_dout : '0;
`endif

   assign inv_busy = inv_busy_q;
   assign inv_done = inv_done_q;
   assign pwr_rdy  = (state == ST_RUN);
   assign ram_ds   = (state == ST_DS);
   assign ram_sd   = (state == ST_SD);
   assign ram_ls   = 1'b0;

endmodule

// File: tb/tb_npuarc_mmu_ntlb_pd1_ctrl.sv
// Bench for npuarc_mmu_ntlb_pd1_ctrl: RAM model, per-cycle reference model of ports, directed scenarios.
module tb_npuarc_mmu_ntlb_pd1_ctrl;
   localparam int DW = 32;
   localparam int AW = 7;
   localparam int DEPTH = 128;
   localparam int WAKE_CYCLES = 4;
`ifdef NPUARC_NTLB_PD1_RDATA_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int M_WAKE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DS   = 2;
   localparam int M_SD   = 3;

   logic          clk = 1'b0;
   logic          rst_a = 1'b0;
   logic          lkp_req = 1'b0;
   logic [AW-1:0] lkp_addr = '0;
   logic          lkp_ack, lkp_rvalid;
   logic [DW-1:0] lkp_rdata;
   logic          wr_req = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_ack;
   logic          inv_start = 1'b0;
   logic          inv_busy, inv_done;
   logic          pwr_ds_req = 1'b0;
   logic          pwr_sd_req = 1'b0;
   logic          pwr_rdy;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          ram_cs, ram_we, ram_ds, ram_sd, ram_ls;
   bit   [DW-1:0] ram_dout;
   bit   [DW-1:0] ram_mem [DEPTH];

   int n_assert = 0;
   int n_fail   = 0;
   int done_pulses = 0;

   npuarc_mmu_ntlb_pd1_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAKE_CYCLES(WAKE_CYCLES)) dut (
      .clk(clk), .rst_a(rst_a),
      .lkp_req(lkp_req), .lkp_addr(lkp_addr), .lkp_ack(lkp_ack),
      .lkp_rvalid(lkp_rvalid), .lkp_rdata(lkp_rdata),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .inv_start(inv_start), .inv_busy(inv_busy), .inv_done(inv_done),
      .pwr_ds_req(pwr_ds_req), .pwr_sd_req(pwr_sd_req), .pwr_rdy(pwr_rdy),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_cs(ram_cs), .ram_we(ram_we),
      .ram_ds(ram_ds), .ram_sd(ram_sd), .ram_ls(ram_ls), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // Single-port RAM: read data appears the cycle after a read select.
   always @(posedge clk) begin
      if (ram_cs === 1'b1) begin
         if (ram_we === 1'b1) ram_mem[ram_addr] <= ram_din;
         else                 ram_dout <= ram_mem[ram_addr];
      end
   end

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: power mode, wake cycles left, sweep position, expected RAM contents, read return pipe.
   int            m_mode = M_WAKE;
   int            m_wake_left = WAKE_CYCLES;
   bit            m_sweep_on = 1'b0;
   int            m_sweep_idx = 0;
   bit            m_done = 1'b0;
   bit            pv [1:2];
   bit   [DW-1:0] pd [1:2];
   bit   [DW-1:0] m_mem [DEPTH];

   function automatic void m_access(output bit lack, output bit wack, output bit cs, output bit we,
                                    output bit [AW-1:0] a, output bit [DW-1:0] din);
      lack = 1'b0; wack = 1'b0; cs = 1'b0; we = 1'b0; a = '0; din = '0;
      if (m_mode == M_RUN) begin
         if (m_sweep_on) begin
            cs = 1'b1; we = 1'b1; a = AW'(m_sweep_idx);
         end else if (wr_req) begin
            wack = 1'b1; cs = 1'b1; we = 1'b1; a = wr_addr; din = wr_data;
         end else if (lkp_req) begin
            lack = 1'b1; cs = 1'b1; a = lkp_addr;
         end
      end
   endfunction

   always @(posedge clk or negedge rst_a) begin : model
      bit lack, wack, cs, we, busy0, infl;
      bit [AW-1:0] a;
      bit [DW-1:0] din;
      if (!rst_a) begin
         m_mode = M_WAKE; m_wake_left = WAKE_CYCLES;
         m_sweep_on = 1'b0; m_sweep_idx = 0; m_done = 1'b0;
         pv[1] = 1'b0; pv[2] = 1'b0; pd[1] = '0; pd[2] = '0;
      end else begin
         m_access(lack, wack, cs, we, a, din);
         busy0 = m_sweep_on;
         infl  = pv[1] | pv[2];
         pv[2] = (LAT == 2) ? pv[1] : 1'b0;
         pd[2] = pd[1];
         pv[1] = lack;
         pd[1] = lack ? m_mem[a] : '0;
         if (cs && we) m_mem[a] = din;
         m_done = busy0 && (m_sweep_idx == DEPTH - 1);
         if (busy0) begin
            if (m_sweep_idx == DEPTH - 1) m_sweep_on = 1'b0;
            else                          m_sweep_idx++;
         end else if (m_mode == M_RUN && inv_start) begin
            m_sweep_on = 1'b1; m_sweep_idx = 0;
         end
         case (m_mode)
            M_WAKE: begin
               m_wake_left--;
               if (m_wake_left == 0)
                  m_mode = pwr_sd_req ? M_SD : (pwr_ds_req ? M_DS : M_RUN);
            end
            M_RUN: if (!busy0 && !infl && !wr_req && !lkp_req && !inv_start && (pwr_sd_req || pwr_ds_req))
                      m_mode = pwr_sd_req ? M_SD : M_DS;
            M_DS: begin
               if (pwr_sd_req) m_mode = M_SD;
               else if (!pwr_ds_req) begin m_mode = M_WAKE; m_wake_left = WAKE_CYCLES; end
            end
            default: if (!pwr_sd_req && !pwr_ds_req) begin m_mode = M_WAKE; m_wake_left = WAKE_CYCLES; end
         endcase
      end
   end

   always @(negedge clk) begin : compare
      bit lack, wack, cs, we;
      bit [AW-1:0] a;
      bit [DW-1:0] din;
      m_access(lack, wack, cs, we, a, din);
      chk("lkp_ack", 32'(lkp_ack), 32'(lack));
      chk("wr_ack", 32'(wr_ack), 32'(wack));
      chk("ram_cs", 32'(ram_cs), 32'(cs));
      chk("ram_we", 32'(ram_we), 32'(we));
      chk("ram_addr", 32'(ram_addr), 32'(a));
      chk("ram_din", ram_din, din);
      chk("inv_busy", 32'(inv_busy), 32'(m_sweep_on));
      chk("inv_done", 32'(inv_done), 32'(m_done));
      chk("pwr_rdy", 32'(pwr_rdy), 32'(m_mode == M_RUN));
      chk("ram_ds", 32'(ram_ds), 32'(m_mode == M_DS));
      chk("ram_sd", 32'(ram_sd), 32'(m_mode == M_SD));
      chk("ram_ls", 32'(ram_ls), 32'(1'b0));
      chk("lkp_rvalid", 32'(lkp_rvalid), 32'(pv[LAT]));
      if (pv[LAT]) chk("lkp_rdata", lkp_rdata, pd[LAT]);
      if (inv_done === 1'b1) done_pulses++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy(output int k);
      k = 0;
      while (pwr_rdy !== 1'b1 && k < 50) begin step(); k++; end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int k;
      wr_req = 1'b1; wr_addr = a; wr_data = d; k = 0;
      @(negedge clk);
      while (wr_ack !== 1'b1 && k < 400) begin @(negedge clk); k++; end
      chk("wr_ack_timeout", 32'(k < 400), 32'(1));
      step();
      wr_req = 1'b0;
   endtask

   task automatic do_lookup(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
      int k;
      lkp_req = 1'b1; lkp_addr = a; k = 0;
      @(negedge clk);
      while (lkp_ack !== 1'b1 && k < 400) begin @(negedge clk); k++; end
      chk("lkp_ack_timeout", 32'(k < 400), 32'(1));
      step();
      lkp_req = 1'b0;
      lat = 0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (lkp_rvalid === 1'b1) break;
      end
      d = lkp_rdata;
      step();
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int k, lat, busy_cnt, done_k, addr_bad, ds_bad, pulses0;
      logic [DW-1:0] d;
      logic [AW-1:0] seq [3];

      // Reset: all outputs low.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_pwr_rdy", 32'(pwr_rdy), 32'(0));
      chk("reset_lkp_rvalid", 32'(lkp_rvalid), 32'(0));
      chk("reset_ram_ds", 32'(ram_ds), 32'(0));
      @(posedge clk); #1;
      rst_a = 1'b1;
      wait_rdy(k);
      chk("wake_after_reset", 32'(k), 32'(4));

      // Write then immediate lookup of the same entry.
      do_write(7'd5, 32'hDEADBEEF);
      do_lookup(7'd5, d, lat);
      chk("wr_then_rd_data", d, 32'hDEADBEEF);
      chk("rd_latency", 32'(lat), 32'(LAT));

      // Write and lookup collide: write wins, lookup follows with new data.
      wr_req = 1'b1; wr_addr = 7'd3; wr_data = 32'h1234;
      lkp_req = 1'b1; lkp_addr = 7'd3;
      @(negedge clk);
      chk("collide_wr_ack", 32'(wr_ack), 32'(1));
      chk("collide_lkp_ack", 32'(lkp_ack), 32'(0));
      step(); wr_req = 1'b0;
      @(negedge clk);
      chk("collide_lkp_ack_next", 32'(lkp_ack), 32'(1));
      step(); lkp_req = 1'b0;
      k = 0;
      while (k < 10) begin @(negedge clk); k++; if (lkp_rvalid === 1'b1) break; end
      chk("collide_rdata", lkp_rdata, 32'h1234);
      step();

      // Back-to-back lookups, one per cycle.
      seq[0] = 7'd5; seq[1] = 7'd3; seq[2] = 7'd100;
      lkp_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         lkp_addr = seq[i];
         @(negedge clk);
         chk("b2b_lkp_ack", 32'(lkp_ack), 32'(1));
         step();
      end
      lkp_req = 1'b0;
      repeat (3) step();

      // Invalidate-all sweep with an ignored second start.
      inv_start = 1'b1; busy_cnt = 0; done_k = 0; addr_bad = 0;
      for (int j = 1; j < 400; j++) begin
         step();
         inv_start = (j == 50);
         @(negedge clk);
         if (inv_busy === 1'b1) begin
            busy_cnt++;
            if (ram_addr !== AW'(j - 1) || ram_we !== 1'b1 || ram_din !== '0) addr_bad++;
         end
         if (inv_done === 1'b1) begin done_k = j; break; end
      end
      step();
      chk("sweep_done_cycle", 32'(done_k), 32'(129));
      chk("sweep_busy_cycles", 32'(busy_cnt), 32'(128));
      chk("sweep_addr_seq", 32'(addr_bad), 32'(0));
      do_lookup(7'd5, d, lat);
      chk("after_sweep_idx5", d, 32'h0);

      // Deep-sleep request during a sweep waits for the sweep to finish.
      inv_start = 1'b1; step(); inv_start = 1'b0;
      repeat (10) step();
      pwr_ds_req = 1'b1; k = 0; ds_bad = 0;
      while (inv_busy === 1'b1 && k < 300) begin
         if (ram_ds !== 1'b0) ds_bad++;
         step(); k++;
      end
      chk("ds_held_in_sweep", 32'(ds_bad), 32'(0));
      chk("ds_in_done_cycle", 32'(ram_ds), 32'(0));
      step();
      chk("ds_entered", 32'(ram_ds), 32'(1));
      chk("ds_pwr_rdy", 32'(pwr_rdy), 32'(0));
      pwr_sd_req = 1'b1; lkp_req = 1'b1; lkp_addr = 7'd5;
      step();
      chk("sd_ram_sd", 32'(ram_sd), 32'(1));
      chk("sd_ram_ds", 32'(ram_ds), 32'(0));
      chk("sd_no_lkp_ack", 32'(lkp_ack), 32'(0));
      pwr_sd_req = 1'b0; pwr_ds_req = 1'b0; lkp_req = 1'b0;
      step();
      chk("wake_ram_sd", 32'(ram_sd), 32'(0));
      wait_rdy(k);
      chk("wake_after_pwr", 32'(k), 32'(4));

      // Reset in the middle of a sweep.
      do_write(7'd61, 32'h0BADF00D);
      do_write(7'd20, 32'h20202020);
      inv_start = 1'b1; step(); inv_start = 1'b0; k = 0;
      while (!(inv_busy === 1'b1 && ram_addr == 7'd60) && k < 300) begin @(negedge clk); k++; end
      #1 rst_a = 1'b0;
      #1;
      chk("rst_sweep_busy", 32'(inv_busy), 32'(0));
      chk("rst_ram_cs", 32'(ram_cs), 32'(0));
      @(posedge clk); @(posedge clk); #1;
      rst_a = 1'b1;
      pulses0 = done_pulses;
      wait_rdy(k);
      chk("wake_after_midrst", 32'(k), 32'(4));
      do_write(7'd100, 32'hA5A50001);
      do_lookup(7'd100, d, lat);
      chk("post_rst_rd", d, 32'hA5A50001);
      do_lookup(7'd61, d, lat);
      chk("aborted_sweep_idx61", d, 32'h0BADF00D);
      do_lookup(7'd20, d, lat);
      chk("aborted_sweep_idx20", d, 32'h0);
      chk("no_done_after_rst", 32'(done_pulses - pulses0), 32'(0));

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
